// File: rtl/bridge_gate_scheduler.sv
// Full-bridge gate sequencer: turns the one-bit switching command into
// shoot-through-free gate patterns with dead time, minimum on-time and fault latch.
module bridge_gate_scheduler #(
  parameter int DT_WIDTH  = 8,
  parameter int MIN_ON    = 20,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_sigma,
  input  logic [DT_WIDTH-1:0]  i_deadtime,
  input  logic                 i_fault,
  input  logic                 i_fault_clear,
  output logic [3:0]           o_gate,
  output logic [2:0]           o_state,
  output logic                 o_fault,
  output logic [CNT_WIDTH-1:0] o_switch_count
);

  localparam int MON_W = (MIN_ON > 0) ? $clog2(MIN_ON + 1) : 1;
  localparam logic [DT_WIDTH-1:0] DT_ONE  = DT_WIDTH'(1);
  localparam logic [MON_W-1:0]    MON_ONE = MON_W'(1);
  localparam logic [MON_W-1:0]    MON_LD  = MON_W'(MIN_ON);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DEAD  = 3'd1,
    ST_POS   = 3'd2,
    ST_NEG   = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic                   target_q, target_d;
  logic [DT_WIDTH-1:0]    dead_q, dead_d;
  logic [MON_W-1:0]       minon_q, minon_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   fault_q, fault_d;
  logic [3:0]             gate_q, gate_d;
  logic                   start_dead;
  logic [DT_WIDTH-1:0]    dead_load;

  // Counter expires at zero, so a dead time of D occupies max(D,1) cycles.
  assign dead_load = (i_deadtime == '0) ? '0 : i_deadtime - DT_ONE;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d    = state_q;
    target_d   = target_q;
    dead_d     = dead_q;
    minon_d    = minon_q;
    cnt_d      = cnt_q;
    fault_d    = fault_q;
    start_dead = 1'b0;

    if (state_q == ST_FAULT) begin
      if (i_fault_clear && !i_fault) begin
        state_d = ST_IDLE;
        fault_d = 1'b0;
      end
    end else if (i_fault) begin
      state_d = ST_FAULT;
      fault_d = 1'b1;
    end else if (!i_enable && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: start_dead = i_enable;
        ST_DEAD: begin
          if (dead_q == '0) begin
            state_d = target_q ? ST_POS : ST_NEG;
            minon_d = MON_LD;
            cnt_d   = cnt_q + CNT_WIDTH'(1);
          end else begin
            dead_d = dead_q - DT_ONE;
          end
        end
        ST_POS, ST_NEG: begin
          if (minon_q != '0) begin
            minon_d = minon_q - MON_ONE;
          end else if (i_sigma != (state_q == ST_POS)) begin
            start_dead = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (start_dead) begin
      state_d  = ST_DEAD;
      target_d = i_sigma;
      dead_d   = dead_load;
    end

    // Gates decode the next state so the pins change on the same edge as o_state.
    case (state_d)
      ST_POS:  gate_d = 4'b1001;
      ST_NEG:  gate_d = 4'b0110;
      default: gate_d = 4'b0000;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      target_q <= 1'b0;
      dead_q   <= '0;
      minon_q  <= '0;
      cnt_q    <= '0;
      fault_q  <= 1'b0;
      gate_q   <= 4'b0000;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      dead_q   <= dead_d;
      minon_q  <= minon_d;
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
      gate_q   <= gate_d;
    end
  end

  assign o_gate         = gate_q;
  assign o_state        = state_q;
  assign o_fault        = fault_q;
  assign o_switch_count = cnt_q;

endmodule

// File: tb/tb_bridge_gate_scheduler.sv
// Self-checking bench for bridge_gate_scheduler: directed scenarios followed by
// random stimulus, all compared each cycle against a cycle-numbered reference model.
module tb_bridge_gate_scheduler;

  localparam int DT_W   = 8;
  localparam int MIN_ON = 20;
  localparam int CW     = 4;

  logic            clk = 1'b0;
  logic            rst, en, sig, flt, clr;
  logic [DT_W-1:0] dt;
  logic [3:0]      gate;
  logic [2:0]      st;
  logic            fo;
  logic [CW-1:0]   cnt;

  int n_tests = 0;
  int n_fail  = 0;

  bridge_gate_scheduler #(.DT_WIDTH(DT_W), .MIN_ON(MIN_ON), .CNT_WIDTH(CW)) dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_sigma(sig), .i_deadtime(dt),
    .i_fault(flt), .i_fault_clear(clr), .o_gate(gate), .o_state(st),
    .o_fault(fo), .o_switch_count(cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: modes 0..4 mirror the published state codes; timing is kept
  // as absolute cycle numbers (last dead cycle, conduction start) instead of counters.
  int     m_mode;
  bit     m_tgt;
  int     m_cnt;
  bit     m_fault;
  longint cyc, m_dead_last, m_on_start;

  function automatic int exp_gate();
    if (m_mode == 2) return 9;
    if (m_mode == 3) return 6;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_tgt = 0; m_cnt = 0; m_fault = 0;
    m_dead_last = 0; m_on_start = 0;
  endtask

  task automatic enter_dead();
    int len;
    len = (int'(dt) < 1) ? 1 : int'(dt);
    m_mode = 1;
    m_tgt = sig;
    m_dead_last = cyc + len;
  endtask

  task automatic model_step();
    if (m_mode == 4) begin
      if (clr && !flt) begin m_mode = 0; m_fault = 0; end
    end else if (flt) begin
      m_mode = 4; m_fault = 1;
    end else if (m_mode != 0 && !en) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (en) enter_dead();
    end else if (m_mode == 1) begin
      if (cyc == m_dead_last) begin
        m_mode = m_tgt ? 2 : 3;
        m_on_start = cyc + 1;
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
    end else begin
      if (cyc >= m_on_start + MIN_ON && sig != (m_mode == 2)) enter_dead();
    end
  endtask

  task automatic compare_all();
    check("gate", 32'(gate), 32'(exp_gate()));
    check("state", 32'(st), 32'(m_mode));
    check("fault", 32'(fo), 32'(m_fault));
    check("count", 32'(cnt), 32'(m_cnt));
    check("shoot", 32'((gate[0] & gate[1]) | (gate[2] & gate[3])), 32'd0);
  endtask

  task automatic tick();
    if (rst) model_reset();
    else     model_step();
    cyc++;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    int n;
    int base;
    rst = 1'b1; en = 1'b0; sig = 1'b0; dt = '0; flt = 1'b0; clr = 1'b0;
    cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gate", 32'(gate), 32'd0);
    check("rst_state", 32'(st), 32'd0);
    check("rst_fault", 32'(fo), 32'd0);
    check("rst_count", 32'(cnt), 32'd0);
    rst = 1'b0;

    // Enable start with a 5-cycle dead time.
    en = 1'b1; sig = 1'b1; dt = 8'd5;
    tick(); check("t1_dead", 32'(gate), 32'd0);
    repeat (4) begin tick(); check("t1_dead", 32'(gate), 32'd0); end
    tick(); check("t1_pos", 32'(gate), 32'h9); check("t1_cnt", 32'(cnt), 32'd1);

    // Commutation POS -> NEG with 3 dead cycles.
    repeat (25) tick();
    sig = 1'b0; dt = 8'd3;
    repeat (3) begin tick(); check("t2_dead", 32'(gate), 32'd0); end
    tick(); check("t2_neg", 32'(gate), 32'h6);

    // Early toggle is held until min-on expires: MIN_ON+1 conduction cycles.
    repeat (3) tick();
    sig = 1'b1;
    n = 4;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (gate == 4'h6) n++;
      else break;
    end
    check("t3_minon", 32'(n), 32'(MIN_ON + 1));
    repeat (3) tick();
    check("t3_pos", 32'(gate), 32'h9);

    // Glitch inside min-on window causes no commutation.
    repeat (5) tick();
    sig = 1'b0;
    repeat (2) tick();
    sig = 1'b1;
    repeat (30) begin tick(); check("glitch", 32'(gate), 32'h9); end

    // Zero dead time still gives one dead cycle.
    dt = 8'd0; sig = 1'b0;
    tick(); check("dt0_dead", 32'(gate), 32'd0);
    tick(); check("dt0_neg", 32'(gate), 32'h6);

    // Changing dead time during DEAD does not alter the current one.
    repeat (25) tick();
    dt = 8'd6; sig = 1'b1;
    tick();
    dt = 8'd1;
    n = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (gate == 4'h0) n++;
      else break;
    end
    check("dt_hold", 32'(n), 32'd6);
    check("dt_hold_pos", 32'(gate), 32'h9);

    // Fault in NEG, ignored clear, valid clear, re-enable via DEAD.
    repeat (25) tick();
    sig = 1'b0; dt = 8'd2;
    repeat (3) tick();
    check("f_neg", 32'(gate), 32'h6);
    flt = 1'b1;
    tick();
    check("f_gate", 32'(gate), 32'd0); check("f_flag", 32'(fo), 32'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("f_clr_ignored", 32'(st), 32'd4);
    flt = 1'b0; tick();
    check("f_held", 32'(st), 32'd4);
    clr = 1'b1; tick(); clr = 1'b0;
    check("f_clr_state", 32'(st), 32'd0); check("f_clr_flag", 32'(fo), 32'd0);
    tick(); check("f_reen_dead", 32'(st), 32'd1);
    repeat (2) tick();
    check("f_reen_neg", 32'(gate), 32'h6);

    // Seventeen commutations wrap the 4-bit counter.
    base = m_cnt;
    repeat (17) begin
      repeat (22) tick();
      sig = ~sig; dt = 8'd1;
      repeat (2) tick();
    end
    check("wrap", 32'(cnt), 32'((base + 17) % (1 << CW)));

    // Asynchronous reset in the middle of DEAD.
    repeat (22) tick();
    sig = ~sig; dt = 8'd8;
    tick();
    check("ar_in_dead", 32'(st), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_gate", 32'(gate), 32'd0);
    check("ar_state", 32'(st), 32'd0);
    check("ar_count", 32'(cnt), 32'd0);
    check("ar_fault", 32'(fo), 32'd0);
    tick();
    rst = 1'b0;

    // Randomised operation against the model.
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(0, 99) < 96);
      if ($urandom_range(0, 29) == 0) sig = ~sig;
      dt  = DT_W'($urandom_range(0, 6));
      flt = ($urandom_range(0, 199) == 0) ? 1'b1 : (flt && $urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bridge_gate_scheduler.md
# bridge_gate_scheduler

Sequences the four gate signals of the full-bridge resonant converter from the one-bit switching decision of the hybrid controller. The block enforces a runtime-programmable dead time on every commutation, a minimum on-time per conduction state, ordered enable/disable, and a latched fault shutdown. It sits between the hybrid control law and the gate-driver pins and produces registered, shoot-through-free gate patterns.

## Interface

Parameters:
- DT_WIDTH, 8, width of the dead-time input, in clock cycles
- MIN_ON, 20, minimum cycles a conduction state is held before a new commutation is accepted; 0 is legal and disables the limit
- CNT_WIDTH, 16, width of the commutation counter

Ports:
- i_clock  input  1  system clock
- i_reset  input  1  asynchronous, active-high reset
- i_enable  input  1  1 = bridge switching allowed
- i_sigma  input  1  switching command: 1 = positive state, 0 = negative state
- i_deadtime  input  DT_WIDTH  dead time in cycles, sampled on DEAD entry
- i_fault  input  1  external fault (level)
- i_fault_clear  input  1  single-cycle pulse that clears a latched fault
- o_gate  output  4  [0]=S1 leg-A high, [1]=S2 leg-A low, [2]=S3 leg-B high, [3]=S4 leg-B low
- o_state  output  3  encoded FSM state: IDLE=0, DEAD=1, POS=2, NEG=3, FAULT=4
- o_fault  output  1  latched fault flag
- o_switch_count  output  CNT_WIDTH  number of completed entries into POS or NEG, wrapping

## Operation

- Gate patterns: POS = 4'b1001, NEG = 4'b0110, IDLE/DEAD/FAULT = 4'b0000. No other value is ever driven. o_gate is a registered decode of the state.
- Reset values: state IDLE, o_gate 0000, o_fault 0, o_switch_count 0, internal counters 0, target 0.
- IDLE: if i_enable=1 and i_fault=0, latch target=i_sigma, load dead counter, go DEAD.
- DEAD: the dead counter decrements every cycle. When it expires, go POS if target=1, else NEG. Load the min-on counter with MIN_ON, and increment o_switch_count (wraps from all-ones to 0). Changes on i_sigma during DEAD are ignored because the target is fixed at entry.
- POS/NEG: the min-on counter decrements to 0 and saturates. When it is 0 and i_sigma differs from the current state, latch target=i_sigma, load the dead counter, and go DEAD. While min-on has not expired, a differing i_sigma is held off. It is acted on once the counter is 0, if it is still differing.
- Disable: i_enable=0 in DEAD, POS or NEG goes IDLE on the next edge. Re-enabling always passes through DEAD.
- Fault: i_fault=1 in any non-FAULT state goes FAULT and sets o_fault. FAULT exits to IDLE only on i_fault_clear=1 with i_fault=0 in the same cycle, which also clears o_fault. A clear while i_fault=1 is ignored.
- Priority per cycle: i_fault > i_enable=0 > commutation/dead-time progress.
- Dead-time length: DEAD is held for max(i_deadtime,1) cycles. The value sampled on DEAD entry is used; later changes to i_deadtime affect only the next DEAD.

## Timing

- All outputs are registered; there is no combinational path from input to output.
- Commutation: i_sigma toggles in cycle t with min-on expired. The state is DEAD and o_gate=0000 from t+1. The new pattern appears at t+1+max(D,1), together with o_switch_count+1.
- Enable start: i_enable rises in cycle t from IDLE. o_gate is 0000 through t+max(D,1), then the pattern selected by i_sigma as sampled at t.
- Fault/disable: o_gate is 0000 one cycle after the input is sampled, from any state.
- Minimum conduction length is MIN_ON+1 cycles at the gate output.
- An asynchronous i_reset mid-pulse forces o_gate=0000 immediately, without waiting for a clock edge.

## Test plan

- Reset, then i_enable=1, i_sigma=1, i_deadtime=5: o_gate=0000 for 5 cycles, then 1001; o_switch_count=1.
- In POS with MIN_ON=20 expired, toggle i_sigma to 0 with i_deadtime=3: 1001 → 0000 for exactly 3 cycles → 0110. A checker confirms leg-A and leg-B bits are never both high.
- Toggle i_sigma 4 cycles after POS entry (MIN_ON=20): stays 1001 until 21 cycles after POS entry, then DEAD. A glitch that returns to 1 before expiry causes no commutation.
- i_deadtime=0 gives 1 dead cycle. Change i_deadtime during DEAD: the current DEAD keeps the old length.
- i_fault=1 in NEG: o_gate=0000 and o_fault=1 next cycle. A clear pulse while i_fault=1 is ignored. A clear with i_fault=0 returns to IDLE, and re-enable passes through DEAD.
- With CNT_WIDTH=4, run 17 commutations: o_switch_count wraps 15 → 0 → 1. Assert i_reset mid-DEAD: all outputs return to reset values asynchronously.
